dds_axil_slave: RTL

//  AXI4-Lite slave front-end for the DDS core. Terminates AXI4-Lite write/read transactions from the PS
//  and converts each accepted write into a single-cycle register-map write strobe (addr + data) feeding
//  the DDS register map directly downstream. Read data comes from CTRL/DATA/STAT register values returned
//  by the register map. Write and read channels run independent FSMs.

---
 rtl/dds_axil_slave.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/dds_axil_slave.sv
// AXI4-Lite slave front-end for the DDS core.
// Each accepted write becomes a one-cycle register-map strobe (addr + data).
// Reads return CTRL/DATA/STAT values supplied by the register map.
// The write and read channels run independent FSMs. Every AXI output is a
// register, so no AXI output depends combinationally on an AXI input.
//
// Handshake rule: a transfer happens on a rising edge where both valid and
// ready are high. Valid, once raised, holds its payload stable until that
// edge. Ready is registered and never depends on valid in the same cycle.
module dds_axil_slave #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SIG_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    o_reg_wr,
  output logic [31:0]             o_reg_addrs,
  output logic [SIG_WIDTH-1:0]    o_reg_data,
  input  logic [31:0]             i_ctrl_reg,
  input  logic [31:0]             i_data_reg,
  input  logic [31:0]             i_stat_reg,
  output logic [1:0]              wr_state,
  output logic                    rd_state
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_WAIT = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RESP = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]              wstate;
  logic [0:0]              rstate;
  logic                    aw_have;
  logic                    w_have;
  logic [3:0]              awaddr_q;
  logic [SIG_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;

  logic                    aw_hs;
  logic                    w_hs;
  logic                    got_aw;
  logic                    got_w;
  logic [3:0]              wr_addr;
  logic [SIG_WIDTH-1:0]    wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic                    wr_writable;
  logic                    ar_hs;
  logic [DATA_WIDTH-1:0]   rd_mux;
  logic                    rd_err;
  logic                    unused_wdata;

  assign wr_state = wstate;
  assign rd_state = rstate;

  // Upper write-data bits are not forwarded to the register map.
  assign unused_wdata = ^s_axi_wdata[DATA_WIDTH-1:SIG_WIDTH];

  // Write-side capture view: a beat arriving this edge counts as captured.
  always_comb begin
    aw_hs       = s_axi_awvalid & s_axi_awready;
    w_hs        = s_axi_wvalid & s_axi_wready;
    got_aw      = aw_have | aw_hs;
    got_w       = w_have | w_hs;
    wr_addr     = aw_hs ? s_axi_awaddr[3:0] : awaddr_q;
    wr_data     = w_hs ? s_axi_wdata[SIG_WIDTH-1:0] : wdata_q;
    wr_strb     = w_hs ? s_axi_wstrb : wstrb_q;
    wr_writable = (wr_addr == 4'h0) || (wr_addr == 4'h4);
  end

  // Read address decode; unmapped or unaligned offsets return zero with SLVERR.
  always_comb begin
    ar_hs  = s_axi_arvalid & s_axi_arready;
    rd_mux = '0;
    rd_err = 1'b0;
    case (s_axi_araddr[3:0])
      4'h0:    rd_mux = i_ctrl_reg;
      4'h4:    rd_mux = i_data_reg;
      4'h8:    rd_mux = i_stat_reg;
      default: rd_err = 1'b1;
    endcase
  end

  // Write FSM: collect AW and W in any order, then strobe and respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate        <= W_IDLE;
      aw_have       <= 1'b0;
      w_have        <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      o_reg_wr      <= 1'b0;
      o_reg_addrs   <= '0;
      o_reg_data    <= '0;
    end else begin
      o_reg_wr <= 1'b0;
      case (wstate)
        W_IDLE, W_WAIT: begin
          if (aw_hs) awaddr_q <= s_axi_awaddr[3:0];
          if (w_hs) begin
            wdata_q <= s_axi_wdata[SIG_WIDTH-1:0];
            wstrb_q <= s_axi_wstrb;
          end
          aw_have       <= got_aw;
          w_have        <= got_w;
          s_axi_awready <= ~got_aw;
          s_axi_wready  <= ~got_w;
          if (got_aw && got_w) begin
            wstate       <= W_RESP;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_writable ? RESP_OKAY : RESP_SLVERR;
            // An all-zero strobe is acknowledged but changes nothing.
            if (wr_writable && (wr_strb != '0)) begin
              o_reg_wr    <= 1'b1;
              o_reg_addrs <= {28'h0, wr_addr};
              o_reg_data  <= wr_data;
            end
          end else if (got_aw || got_w) begin
            wstate <= W_WAIT;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            wstate        <= W_IDLE;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            aw_have       <= 1'b0;
            w_have        <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM: register the selected value at the AR edge and hold it until rready.
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate        <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            rstate        <= R_RESP;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rdata   <= rd_mux;
            s_axi_rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            rstate        <= R_IDLE;
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule
